bloom_lookup: RTL

Membership-test stage directly downstream of the CRC hasher. It consumes `{data, hashes}` beats and looks each hash up in its own 2^HASH_W x 1-bit bank. It forwards only strings whose bits are set in every bank, i.e. Bloom-filter candidates. It also owns bank programming (insert port) and a bank-clear sweep, and keeps lookup/hit statistics.

---
 rtl/bloom_lookup.sv | 119 +++++++++++
 1 files changed

// File: rtl/bloom_lookup.sv
// rtl/bloom_lookup.sv - Bloom-filter membership stage: per-hash 1-bit banks, insert port, clear sweep, stats
module bloom_lookup #(
    parameter int BYTE_W     = 8,
    parameter int STR_SIZE   = 6,
    parameter int HASHES_CNT = 12,
    parameter int HASH_W     = 13,
    parameter int CNT_W      = 32
) (
    input  logic                         clk_i,
    input  logic                         srst_i,
    input  logic [HASHES_CNT*HASH_W-1:0] hashes_i,
    input  logic [STR_SIZE*BYTE_W-1:0]   data_i,
    input  logic                         hashes_data_valid_i,
    output logic                         hashes_data_ready_o,
    output logic [STR_SIZE*BYTE_W-1:0]   match_data_o,
    output logic                         match_valid_o,
    input  logic                         match_ready_i,
    input  logic [HASHES_CNT*HASH_W-1:0] wr_hashes_i,
    input  logic                         wr_valid_i,
    output logic                         wr_ready_o,
    input  logic                         clear_i,
    output logic                         busy_o,
    output logic [CNT_W-1:0]             lookups_cnt_o,
    output logic [CNT_W-1:0]             hits_cnt_o
);
    localparam int DEPTH = 2 ** HASH_W;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                       state;
    logic [HASH_W-1:0]            addr;
    logic                         en;
    logic                         accept;
    logic                         wr_fire;
    logic                         hit;
    logic                         s1_valid;
    logic [STR_SIZE*BYTE_W-1:0]   s1_data;
    logic [HASHES_CNT-1:0]        rd_bits;

    assign busy_o              = (state == CLEAR);
    assign en                  = ~match_valid_o | match_ready_i;
    assign hashes_data_ready_o = ~busy_o & en;
    assign wr_ready_o          = ~busy_o;
    assign accept              = hashes_data_valid_i & hashes_data_ready_o;
    assign wr_fire             = wr_valid_i & wr_ready_o;
    assign hit                 = &rd_bits;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state <= CLEAR;
            addr  <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    addr <= addr + 1'b1;
                    if (addr == {HASH_W{1'b1}})
                        state <= RUN;
                end
                RUN: begin
                    if (clear_i) begin
                        state <= CLEAR;
                        addr  <= '0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // The sweep owns the write port while busy; inserts are only accepted when idle.
    for (genvar n = 0; n < HASHES_CNT; n++) begin : g_bank
        logic              mem [DEPTH];
        logic              rd_q;
        logic              we;
        logic              wbit;
        logic [HASH_W-1:0] waddr;

        always_comb begin
            we    = busy_o | wr_fire;
            wbit  = ~busy_o;
            waddr = busy_o ? addr : wr_hashes_i[n*HASH_W +: HASH_W];
        end

        always_ff @(posedge clk_i) begin
            if (we)
                mem[waddr] <= wbit;
            if (en)
                rd_q <= mem[hashes_i[n*HASH_W +: HASH_W]];
        end

        assign rd_bits[n] = rd_q;
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            s1_valid      <= 1'b0;
            s1_data       <= '0;
            match_valid_o <= 1'b0;
            match_data_o  <= '0;
        end else if (en) begin
            s1_valid      <= accept;
            s1_data       <= data_i;
            match_valid_o <= s1_valid & hit;
            match_data_o  <= s1_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            lookups_cnt_o <= '0;
            hits_cnt_o    <= '0;
        end else begin
            if (accept && lookups_cnt_o != {CNT_W{1'b1}})
                lookups_cnt_o <= lookups_cnt_o + 1'b1;
            if (en && s1_valid && hit && hits_cnt_o != {CNT_W{1'b1}})
                hits_cnt_o <= hits_cnt_o + 1'b1;
        end
    end
endmodule
